// File: rtl/ps2_kbd_decoder.sv
// PS/2 keyboard receiver (scan code set 2) presenting the held key as an ASCII level.
// Handles pin synchronization, framing/parity, timeout, F0/E0 prefixes and the key map.
module ps2_kbd_decoder #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] key,
  output logic       key_valid,
  output logic [7:0] scan_code,
  output logic       frame_err
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {R_IDLE, R_DATA, R_PAR, R_STOP} rx_t;
  typedef enum logic [1:0] {D_NORM, D_BRK, D_EXT, D_EXTBRK} dec_t;

  // clk_s[0]/[1] are the synchronizer stages, clk_s[2] is sync2 one cycle back
  logic [2:0]    clk_s;
  logic [1:0]    dat_s;
  logic          fall, din;
  rx_t           rx_st;
  dec_t          dec_st;
  logic [2:0]    bit_cnt;
  logic [7:0]    sh;
  logic          par;
  logic [CW-1:0] to_cnt;
  logic          byte_rdy;
  logic [7:0]    asc;

  assign fall = clk_s[2] & ~clk_s[1];
  assign din  = dat_s[1];

  function automatic logic [7:0] to_ascii(input logic [7:0] c);
    case (c)
      8'h1C: to_ascii = "A";  8'h32: to_ascii = "B";  8'h21: to_ascii = "C";
      8'h23: to_ascii = "D";  8'h24: to_ascii = "E";  8'h2B: to_ascii = "F";
      8'h34: to_ascii = "G";  8'h33: to_ascii = "H";  8'h43: to_ascii = "I";
      8'h3B: to_ascii = "J";  8'h42: to_ascii = "K";  8'h4B: to_ascii = "L";
      8'h3A: to_ascii = "M";  8'h31: to_ascii = "N";  8'h44: to_ascii = "O";
      8'h4D: to_ascii = "P";  8'h15: to_ascii = "Q";  8'h2D: to_ascii = "R";
      8'h1B: to_ascii = "S";  8'h2C: to_ascii = "T";  8'h3C: to_ascii = "U";
      8'h2A: to_ascii = "V";  8'h1D: to_ascii = "W";  8'h22: to_ascii = "X";
      8'h35: to_ascii = "Y";  8'h1A: to_ascii = "Z";
      8'h45: to_ascii = "0";  8'h16: to_ascii = "1";  8'h1E: to_ascii = "2";
      8'h26: to_ascii = "3";  8'h25: to_ascii = "4";  8'h2E: to_ascii = "5";
      8'h36: to_ascii = "6";  8'h3D: to_ascii = "7";  8'h3E: to_ascii = "8";
      8'h46: to_ascii = "9";  8'h29: to_ascii = 8'h20;
      default: to_ascii = 8'h00;
    endcase
  endfunction

  assign asc = to_ascii(sh);

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_s <= 3'b111;
      dat_s <= 2'b11;
    end else begin
      clk_s <= {clk_s[1:0], ps2_clk};
      dat_s <= {dat_s[0], ps2_data};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_st     <= R_IDLE;
      bit_cnt   <= 3'd0;
      sh        <= 8'h00;
      par       <= 1'b0;
      to_cnt    <= '0;
      byte_rdy  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      byte_rdy  <= 1'b0;
      frame_err <= 1'b0;
      if (fall) begin
        to_cnt <= '0;
        case (rx_st)
          R_IDLE: if (!din) begin
            rx_st   <= R_DATA;
            bit_cnt <= 3'd0;
          end
          R_DATA: begin
            sh      <= {din, sh[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) rx_st <= R_PAR;
          end
          R_PAR: begin
            par   <= din;
            rx_st <= R_STOP;
          end
          R_STOP: begin
            if (din && (^{sh, par})) byte_rdy  <= 1'b1;
            else                     frame_err <= 1'b1;
            rx_st <= R_IDLE;
          end
          default: rx_st <= R_IDLE;
        endcase
      end else if (rx_st == R_IDLE) begin
        to_cnt <= '0;
      end else if (to_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
        // stalled partial frame: drop it, decoder prefix state is kept
        rx_st     <= R_IDLE;
        frame_err <= 1'b1;
        to_cnt    <= '0;
      end else begin
        to_cnt <= to_cnt + 1'b1;
      end
    end
  end

  // sh is stable here: the next fall is at least 4 cycles after byte_rdy
  always_ff @(posedge clk) begin
    if (rst) begin
      dec_st    <= D_NORM;
      key       <= 8'h00;
      key_valid <= 1'b0;
      scan_code <= 8'h00;
    end else begin
      key_valid <= 1'b0;
      if (byte_rdy) begin
        scan_code <= sh;
        case (dec_st)
          D_NORM: begin
            if      (sh == 8'hF0) dec_st <= D_BRK;
            else if (sh == 8'hE0) dec_st <= D_EXT;
            else begin
              key       <= asc;
              key_valid <= 1'b1;
            end
          end
          D_BRK: begin
            if (asc != 8'h00 && asc == key) begin
              key       <= 8'h00;
              key_valid <= 1'b1;
            end
            dec_st <= D_NORM;
          end
          D_EXT:   dec_st <= (sh == 8'hF0) ? D_EXTBRK : D_NORM;
          default: dec_st <= D_NORM;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_kbd_decoder.sv
// Bench for ps2_kbd_decoder: directed frame table, timeout/reset sequences,
// and random frames checked against a prefix-queue reference model.
module tb_ps2_kbd_decoder;
  localparam int TO = 200;

  logic clk = 0, rst = 1, ps2_clk = 1, ps2_data = 1;
  logic [7:0] key, scan_code;
  logic key_valid, frame_err;

  ps2_kbd_decoder #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .key(key), .key_valid(key_valid), .scan_code(scan_code), .frame_err(frame_err));

  always #5 clk = ~clk;

  int cyc = 0, kv_cnt = 0, fe_cnt = 0, kv_cyc = 0, fe_cyc = 0, fall_cyc = 0, overlap = 0;
  int errors = 0, checks = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) if (!rst) begin
    if (key_valid) begin kv_cnt++; kv_cyc = cyc; end
    if (frame_err) begin fe_cnt++; fe_cyc = cyc; end
    if (key_valid && frame_err) overlap++;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference map built from the key table
  string keys = "ABCDEFGHIJKLMNOPQRSTUVWXYZ0123456789 ";
  logic [7:0] codes [37] = '{8'h1C,8'h32,8'h21,8'h23,8'h24,8'h2B,8'h34,8'h33,8'h43,8'h3B,
                             8'h42,8'h4B,8'h3A,8'h31,8'h44,8'h4D,8'h15,8'h2D,8'h1B,8'h2C,
                             8'h3C,8'h2A,8'h1D,8'h22,8'h35,8'h1A,8'h45,8'h16,8'h1E,8'h26,
                             8'h25,8'h2E,8'h36,8'h3D,8'h3E,8'h46,8'h29};

  function automatic logic [7:0] asc_of(input logic [7:0] c);
    for (int i = 0; i < 37; i++) if (codes[i] == c) return keys[i];
    return 8'h00;
  endfunction

  logic [7:0] m_key = 0, m_scan = 0;
  logic [7:0] pend [$];

  task automatic m_byte(input logic [7:0] b, output int kv);
    logic [7:0] a;
    a = asc_of(b);
    kv = 0;
    if (pend.size() == 0) begin
      if (b == 8'hF0 || b == 8'hE0) pend.push_back(b);
      else begin m_key = a; kv = 1; end
    end else if (pend.size() == 1 && pend[0] == 8'hF0) begin
      if (a != 0 && a == m_key) begin m_key = 0; kv = 1; end
      pend.delete();
    end else if (pend.size() == 1) begin
      if (b == 8'hF0) pend.push_back(b); else pend.delete();
    end else pend.delete();
    m_scan = b;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop, input int nbits);
    logic [10:0] fr;
    fr = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      @(posedge clk); #1 ps2_data = fr[i];
      repeat (3) @(posedge clk);
      #1 ps2_clk = 0; fall_cyc = cyc;
      repeat (4) @(posedge clk);
      #1 ps2_clk = 1;
    end
    repeat (6) @(posedge clk);
    #1 ps2_data = 1;
  endtask

  typedef struct {
    logic [7:0] b; bit bp; bit bs;
    logic [7:0] k; logic [7:0] sc; int kv; int fe;
  } vec_t;
  vec_t tbl [20];

  initial begin
    int kv0, fe0, kvm;
    tbl[0]  = '{8'h24,0,0,8'h45,8'h24,1,0};
    tbl[1]  = '{8'hF0,0,0,8'h45,8'hF0,0,0};
    tbl[2]  = '{8'h24,0,0,8'h00,8'h24,1,0};
    tbl[3]  = '{8'h23,0,0,8'h44,8'h23,1,0};
    tbl[4]  = '{8'h2B,0,0,8'h46,8'h2B,1,0};
    tbl[5]  = '{8'hF0,0,0,8'h46,8'hF0,0,0};
    tbl[6]  = '{8'h23,0,0,8'h46,8'h23,0,0};
    tbl[7]  = '{8'h32,1,0,8'h46,8'h23,0,1};
    tbl[8]  = '{8'h32,0,0,8'h42,8'h32,1,0};
    tbl[9]  = '{8'h1C,0,1,8'h42,8'h32,0,1};
    tbl[10] = '{8'hE0,0,0,8'h42,8'hE0,0,0};
    tbl[11] = '{8'h75,0,0,8'h42,8'h75,0,0};
    tbl[12] = '{8'hE0,0,0,8'h42,8'hE0,0,0};
    tbl[13] = '{8'hF0,0,0,8'h42,8'hF0,0,0};
    tbl[14] = '{8'h75,0,0,8'h42,8'h75,0,0};
    tbl[15] = '{8'h3A,0,0,8'h4D,8'h3A,1,0};
    tbl[16] = '{8'h29,0,0,8'h20,8'h29,1,0};
    tbl[17] = '{8'h29,0,0,8'h20,8'h29,1,0};
    tbl[18] = '{8'h0E,0,0,8'h00,8'h0E,1,0};
    tbl[19] = '{8'h45,0,0,8'h30,8'h45,1,0};

    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_key", key, 0);
    chk("rst_scan", scan_code, 0);
    chk("rst_kv", key_valid, 0);
    chk("rst_fe", frame_err, 0);

    foreach (tbl[i]) begin
      kv0 = kv_cnt; fe0 = fe_cnt;
      send_frame(tbl[i].b, tbl[i].bp, tbl[i].bs, 11);
      chk($sformatf("tbl%0d_key", i), key, tbl[i].k);
      chk($sformatf("tbl%0d_scan", i), scan_code, tbl[i].sc);
      chk($sformatf("tbl%0d_kv", i), kv_cnt - kv0, tbl[i].kv);
      chk($sformatf("tbl%0d_fe", i), fe_cnt - fe0, tbl[i].fe);
      if (tbl[i].kv == 1) chk($sformatf("tbl%0d_kv_lat", i), kv_cyc - fall_cyc, 4);
      if (tbl[i].fe == 1) chk($sformatf("tbl%0d_fe_lat", i), fe_cyc - fall_cyc, 3);
    end
    m_key = 8'h30; m_scan = 8'h45;

    // Stall after 5 data bits
    kv0 = kv_cnt; fe0 = fe_cnt;
    send_frame(8'h00, 0, 0, 6);
    repeat (TO + 20) @(posedge clk);
    @(negedge clk);
    chk("to_fe", fe_cnt - fe0, 1);
    chk("to_fe_lat", fe_cyc - fall_cyc, TO + 3);
    chk("to_key", key, 8'h30);
    chk("to_kv", kv_cnt - kv0, 0);
    send_frame(8'h2B, 0, 0, 11);
    chk("after_to_key", key, 8'h46);
    chk("after_to_scan", scan_code, 8'h2B);
    m_key = 8'h46; m_scan = 8'h2B;

    for (int n = 0; n < 60; n++) begin
      logic [7:0] b; int r; bit bad, bp, bs;
      r = $urandom_range(0, 99);
      if      (r < 25) b = 8'hF0;
      else if (r < 35) b = 8'hE0;
      else if (r < 80) b = codes[$urandom_range(0, 36)];
      else             b = 8'($urandom_range(0, 255));
      bad = ($urandom_range(0, 9) == 0);
      bp = bad && $urandom_range(0, 1);
      bs = bad && !bp;
      kv0 = kv_cnt; fe0 = fe_cnt;
      send_frame(b, bp, bs, 11);
      if (bad) kvm = 0; else m_byte(b, kvm);
      chk($sformatf("rnd%0d_key", n), key, m_key);
      chk($sformatf("rnd%0d_scan", n), scan_code, m_scan);
      chk($sformatf("rnd%0d_kv", n), kv_cnt - kv0, kvm);
      chk($sformatf("rnd%0d_fe", n), fe_cnt - fe0, bad ? 1 : 0);
    end

    // Reset mid-frame with a pending E0 prefix
    send_frame(8'hF0, 0, 0, 11);
    send_frame(8'hF0, 0, 0, 11);
    send_frame(8'h24, 0, 0, 11);
    chk("pre_rst_key", key, 8'h45);
    send_frame(8'hE0, 0, 0, 11);
    send_frame(8'h1C, 0, 0, 3);
    @(posedge clk); #1 rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("mid_rst_key", key, 0);
    chk("mid_rst_scan", scan_code, 0);
    chk("mid_rst_kv", key_valid, 0);
    chk("mid_rst_fe", frame_err, 0);
    fe0 = fe_cnt;
    repeat (TO + 20) @(posedge clk);
    chk("mid_rst_no_to", fe_cnt - fe0, 0);
    kv0 = kv_cnt;
    send_frame(8'h24, 0, 0, 11);
    chk("post_rst_key", key, 8'h45);
    chk("post_rst_kv", kv_cnt - kv0, 1);

    chk("kv_fe_overlap", overlap, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
